// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, state
// encoding, ALU and mux selector codes, trap causes.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_TRAP      = 4'd12
    } mcState_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // States that wait on the shared memory handshake.
    function automatic logic isMemState(mcState_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Watchdog for memory accesses. Ports: clk, rst_n, clear (restart count),
// count (one more wait cycle), expired (count reached MEM_TIMEOUT).
module mem_wait_timer
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int CntW = $clog2(MEM_TIMEOUT + 1);

    logic [CntW-1:0] waitCnt;

    assign expired = (waitCnt == CntW'(MEM_TIMEOUT));

    // Saturates at MEM_TIMEOUT; the FSM leaves the state on that cycle anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCnt <= '0;
        end else if (clear) begin
            waitCnt <= '0;
        end else if (count && !expired) begin
            waitCnt <= waitCnt + CntW'(1);
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/wb and
// drives datapath strobes; opcode in, strobes + state/trap/trap_cause out.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter bit ENABLE_ADDI = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [1:0]          pc_source,
    output logic [3:0]          state,
    output logic                trap,
    output logic [1:0]          trap_cause
);

    mcState_t   curState;
    mcState_t   nextState;
    logic       isStore;
    logic       waiting;
    logic       expired;
    logic       clearTimer;
    logic       isMem;
    logic       isR;
    logic       isBeq;
    logic       isJ;
    logic       isAddi;
    logic [1:0] aluOpCode;

    assign isMem  = (opcode == OPCODE_W'(OP_LW)) ||
                    (opcode == OPCODE_W'(OP_SW));
    assign isR    = (opcode == OPCODE_W'(OP_RTYPE));
    assign isBeq  = (opcode == OPCODE_W'(OP_BEQ));
    assign isJ    = (opcode == OPCODE_W'(OP_J));
    assign isAddi = ENABLE_ADDI &&
                    (opcode == OPCODE_W'(OP_ADDI));

    assign waiting    = isMemState(curState) && !mem_ready;
    // Any state change restarts the watchdog for the next access.
    assign clearTimer = (nextState != curState);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) uTimer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clearTimer),
        .count  (waiting),
        .expired(expired)
    );

    always_comb begin
        nextState = curState;
        unique case (curState)
            S_FETCH: begin
                if (mem_ready)    nextState = S_DECODE;
                else if (expired) nextState = S_TRAP;
            end
            S_DECODE: begin
                unique case (1'b1)
                    isMem:   nextState = S_MEM_ADDR;
                    isR:     nextState = S_R_EXEC;
                    isBeq:   nextState = S_BRANCH;
                    isJ:     nextState = S_JUMP;
                    isAddi:  nextState = S_ADDI_EXEC;
                    default: nextState = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  nextState = isStore ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready)    nextState = S_MEM_WB;
                else if (expired) nextState = S_TRAP;
            end
            S_MEM_WR: begin
                if (mem_ready)    nextState = S_FETCH;
                else if (expired) nextState = S_TRAP;
            end
            S_R_EXEC:    nextState = S_R_WB;
            S_ADDI_EXEC: nextState = S_ADDI_WB;
            S_MEM_WB,
            S_R_WB,
            S_BRANCH,
            S_JUMP,
            S_ADDI_WB:   nextState = S_FETCH;
            S_TRAP:      nextState = S_TRAP;
            default:     nextState = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curState   <= S_FETCH;
            isStore    <= 1'b0;
            trap       <= 1'b0;
            trap_cause <= CAUSE_NONE;
        end else begin
            curState <= nextState;
            if (curState == S_DECODE) begin
                isStore <= opcode[3];
            end
            // Only DECODE traps on opcode; every other entry is a timeout.
            if (nextState == S_TRAP && curState != S_TRAP) begin
                trap       <= 1'b1;
                trap_cause <= (curState == S_DECODE) ?
                              CAUSE_ILLEGAL : CAUSE_TIMEOUT;
            end
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        aluOpCode     = ALU_ADD;
        pc_source     = PCSRC_ALU;
        unique case (curState)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                // Held off while reset is low so no strobe leaks out.
                ir_write  = mem_ready && rst_n;
                pc_write  = mem_ready && rst_n;
            end
            S_DECODE:   alu_src_b = SRCB_IMMSH2;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                aluOpCode = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                aluOpCode     = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ADDI_WB:  reg_write = 1'b1;
            default: ;
        endcase
    end

    assign alu_op = ALUOP_W'(aluOpCode);
    assign state  = curState;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (default and short-timeout
// without addi) driven from per-instruction expected state traces.
module tb_multicycle_control;
    import mc_pkg::*;

    typedef struct packed {
        logic       pcW;
        logic       pcWC;
        logic       iOrD;
        logic       mRd;
        logic       mWr;
        logic       irW;
        logic       m2r;
        logic       regDst;
        logic       regW;
        logic       srcA;
        logic [1:0] srcB;
        logic [1:0] aluOp;
        logic [1:0] pcSrc;
    } strobes_t;

    typedef struct {
        mcState_t   st;
        logic       rdy;
        logic [5:0] op;
        logic       trap;
        logic [1:0] cause;
    } step_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic [5:0] op[2];
    logic       rdy[2];
    logic       pcW[2], pcWC[2], iOrD[2], mRd[2], mWr[2];
    logic       irW[2], m2r[2], regDst[2], regW[2], srcA[2];
    logic [1:0] srcB[2], aluOp[2], pcSrc[2], cause[2];
    logic [3:0] st[2];
    logic       trp[2];

    int tmoOf[2]  = '{15, 4};
    bit addiOf[2] = '{1'b1, 1'b0};

    int    nAsserts = 0;
    int    nFail = 0;
    step_t plan[$];
    bit    trapped;

    multicycle_control #(
        .OPCODE_W(6), .ALUOP_W(2), .MEM_TIMEOUT(15), .ENABLE_ADDI(1'b1)
    ) dutA (
        .clk(clk), .rst_n(rst_n), .opcode(op[0]), .mem_ready(rdy[0]),
        .pc_write(pcW[0]), .pc_write_cond(pcWC[0]), .i_or_d(iOrD[0]),
        .mem_read(mRd[0]), .mem_write(mWr[0]), .ir_write(irW[0]),
        .mem_to_reg(m2r[0]), .reg_dst(regDst[0]), .reg_write(regW[0]),
        .alu_src_a(srcA[0]), .alu_src_b(srcB[0]), .alu_op(aluOp[0]),
        .pc_source(pcSrc[0]), .state(st[0]), .trap(trp[0]),
        .trap_cause(cause[0])
    );

    multicycle_control #(
        .OPCODE_W(6), .ALUOP_W(2), .MEM_TIMEOUT(4), .ENABLE_ADDI(1'b0)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .opcode(op[1]), .mem_ready(rdy[1]),
        .pc_write(pcW[1]), .pc_write_cond(pcWC[1]), .i_or_d(iOrD[1]),
        .mem_read(mRd[1]), .mem_write(mWr[1]), .ir_write(irW[1]),
        .mem_to_reg(m2r[1]), .reg_dst(regDst[1]), .reg_write(regW[1]),
        .alu_src_a(srcA[1]), .alu_src_b(srcB[1]), .alu_op(aluOp[1]),
        .pc_source(pcSrc[1]), .state(st[1]), .trap(trp[1]),
        .trap_cause(cause[1])
    );

    function automatic strobes_t obsOf(int k);
        return {pcW[k], pcWC[k], iOrD[k], mRd[k], mWr[k], irW[k], m2r[k],
                regDst[k], regW[k], srcA[k], srcB[k], aluOp[k], pcSrc[k]};
    endfunction

    // Strobe table straight from the state descriptions.
    function automatic strobes_t expStrobes(mcState_t s, logic r);
        strobes_t e;
        e = '0;
        case (s)
            S_FETCH:     begin e.mRd = 1; e.srcB = 2'b01; e.irW = r; e.pcW = r; end
            S_DECODE:    e.srcB = 2'b11;
            S_MEM_ADDR:  begin e.srcA = 1; e.srcB = 2'b10; end
            S_MEM_RD:    begin e.mRd = 1; e.iOrD = 1; end
            S_MEM_WB:    begin e.regW = 1; e.m2r = 1; end
            S_MEM_WR:    begin e.mWr = 1; e.iOrD = 1; end
            S_R_EXEC:    begin e.srcA = 1; e.aluOp = 2'b10; end
            S_R_WB:      begin e.regDst = 1; e.regW = 1; end
            S_BRANCH:    begin e.srcA = 1; e.aluOp = 2'b01; e.pcWC = 1; e.pcSrc = 2'b01; end
            S_JUMP:      begin e.pcW = 1; e.pcSrc = 2'b10; end
            S_ADDI_EXEC: begin e.srcA = 1; e.srcB = 2'b10; end
            S_ADDI_WB:   e.regW = 1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pushStep(input mcState_t s, input logic r,
                            input logic [5:0] o, input logic [1:0] c);
        step_t e;
        e.st = s; e.rdy = r; e.op = o;
        e.trap = (s == S_TRAP); e.cause = c;
        plan.push_back(e);
    endtask

    task automatic trapTail(input logic [1:0] c);
        for (int i = 0; i < 3; i++)
            pushStep(S_TRAP, 1'($urandom), 6'($urandom), c);
        trapped = 1'b1;
    endtask

    // A memory access: waits cycles low, then one ready cycle, or a timeout.
    task automatic access(input mcState_t s, input int waits, input int tmo,
                          output bit ok);
        if (waits > tmo) begin
            for (int i = 0; i <= tmo; i++)
                pushStep(s, 1'b0, 6'($urandom), CAUSE_NONE);
            ok = 1'b0;
        end else begin
            for (int i = 0; i < waits; i++)
                pushStep(s, 1'b0, 6'($urandom), CAUSE_NONE);
            pushStep(s, 1'b1, 6'($urandom), CAUSE_NONE);
            ok = 1'b1;
        end
    endtask

    task automatic buildInstr(input int k, input logic [5:0] o,
                              input int fw, input int mw);
        bit ok;
        plan.delete();
        trapped = 1'b0;
        access(S_FETCH, fw, tmoOf[k], ok);
        if (!ok) begin
            trapTail(CAUSE_TIMEOUT);
            return;
        end
        pushStep(S_DECODE, 1'($urandom), o, CAUSE_NONE);
        if (o == OP_LW || o == OP_SW) begin
            pushStep(S_MEM_ADDR, 1'($urandom), 6'($urandom), CAUSE_NONE);
            access(o == OP_SW ? S_MEM_WR : S_MEM_RD, mw, tmoOf[k], ok);
            if (!ok) trapTail(CAUSE_TIMEOUT);
            else if (o == OP_LW) pushStep(S_MEM_WB, 1'($urandom), 6'($urandom), CAUSE_NONE);
        end else if (o == OP_RTYPE) begin
            pushStep(S_R_EXEC, 1'($urandom), 6'($urandom), CAUSE_NONE);
            pushStep(S_R_WB, 1'($urandom), 6'($urandom), CAUSE_NONE);
        end else if (o == OP_BEQ) begin
            pushStep(S_BRANCH, 1'($urandom), 6'($urandom), CAUSE_NONE);
        end else if (o == OP_J) begin
            pushStep(S_JUMP, 1'($urandom), 6'($urandom), CAUSE_NONE);
        end else if (o == OP_ADDI && addiOf[k]) begin
            pushStep(S_ADDI_EXEC, 1'($urandom), 6'($urandom), CAUSE_NONE);
            pushStep(S_ADDI_WB, 1'($urandom), 6'($urandom), CAUSE_NONE);
        end else begin
            trapTail(CAUSE_ILLEGAL);
        end
    endtask

    // Called aligned to a falling edge; leaves aligned to a falling edge.
    task automatic play(input int k, input int n);
        for (int i = 0; i < plan.size() && i < n; i++) begin
            op[k]  = plan[i].op;
            rdy[k] = plan[i].rdy;
            #1;
            check($sformatf("dut%0d step%0d state", k, i), st[k], plan[i].st);
            check($sformatf("dut%0d step%0d strobes", k, i), obsOf(k),
                  expStrobes(plan[i].st, plan[i].rdy));
            check($sformatf("dut%0d step%0d trap", k, i), trp[k], plan[i].trap);
            check($sformatf("dut%0d step%0d cause", k, i), cause[k], plan[i].cause);
            @(negedge clk);
        end
        rdy[k] = 1'b0;
    endtask

    task automatic runInstr(input int k, input logic [5:0] o,
                            input int fw, input int mw);
        buildInstr(k, o, fw, mw);
        play(k, plan.size());
    endtask

    task automatic checkResetState(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s dut%0d state", tag, k), st[k], S_FETCH);
            check($sformatf("%s dut%0d strobes", tag, k), obsOf(k),
                  expStrobes(S_FETCH, 1'b0));
            check($sformatf("%s dut%0d trap", tag, k), trp[k], 1'b0);
            check($sformatf("%s dut%0d cause", tag, k), cause[k], CAUSE_NONE);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rdy[0] = 1'b0; rdy[1] = 1'b0;
        rst_n = 1'b0;
        #1;
        checkResetState("reset");
        rdy[0] = 1'b1; rdy[1] = 1'b1;
        #1;
        checkResetState("resetRdy");
        rdy[0] = 1'b0; rdy[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [5:0] legal[6];
    logic [5:0] pick;

    initial begin
        legal[0] = OP_RTYPE; legal[1] = OP_LW; legal[2] = OP_SW;
        legal[3] = OP_BEQ;   legal[4] = OP_J;  legal[5] = OP_ADDI;
        op[0] = '0; op[1] = '0; rdy[0] = 1'b0; rdy[1] = 1'b0;

        // Directed sequence on the default instance.
        doReset();
        runInstr(0, OP_RTYPE, 0, 0);
        runInstr(0, OP_RTYPE, 0, 0);
        runInstr(0, OP_LW, 0, 3);
        runInstr(0, OP_BEQ, 0, 0);
        runInstr(0, OP_J, 0, 0);
        runInstr(0, OP_ADDI, 1, 0);
        runInstr(0, OP_SW, 2, 0);
        for (int n = 0; n < 30; n++) begin
            pick = legal[$urandom_range(0, 5)];
            runInstr(0, pick, $urandom_range(0, 4), $urandom_range(0, 6));
        end
        runInstr(0, 6'b111111, 0, 0);

        // Abort a store mid-access by reset.
        doReset();
        buildInstr(0, OP_SW, 0, 3);
        play(0, 4);
        op[0] = 6'($urandom); rdy[0] = 1'b0;
        #1;
        check("preReset mem_write", mWr[0], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midReset mem_write", mWr[0], 1'b0);
        check("midReset state", st[0], S_FETCH);
        check("midReset strobes", obsOf(0), expStrobes(S_FETCH, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        runInstr(0, OP_RTYPE, 0, 0);

        // Short-timeout instance without addi.
        doReset();
        runInstr(1, OP_ADDI, 0, 0);
        doReset();
        runInstr(1, 6'b111111, 0, 0);
        doReset();
        runInstr(1, OP_SW, 0, 5);
        doReset();
        runInstr(1, OP_SW, 0, 4);
        runInstr(1, OP_RTYPE, 4, 0);
        runInstr(1, OP_LW, 5, 0);
        for (int n = 0; n < 30; n++) begin
            doReset();
            do begin
                pick = ($urandom_range(0, 7) == 0) ? 6'($urandom)
                                                   : legal[$urandom_range(0, 5)];
                runInstr(1, pick, $urandom_range(0, 5), $urandom_range(0, 5));
            end while (!trapped && ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nAsserts, nFail);
        $finish;
    end

endmodule
